// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared state encoding and LFSR helpers for the burst generator.
package lfsr_pkg;
    localparam int LEN_MIN = 3;
    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;
    typedef enum logic [1:0] {ST_IDLE = 2'b01, ST_RUN = 2'b10} state_t;
    function automatic word_t len_mask(input int n);
        return (word_t'(1) << n) - word_t'(1);
    endfunction
    function automatic word_t lfsr_next(input word_t state, input word_t mask, input int n);
        return ((state << 1) | word_t'(^(state & mask))) & len_mask(n);
    endfunction
endpackage

// File: rtl/lfsr_burst_gen_clk_prescaler.sv
// clk_prescaler: counts 1..div while enabled and ticks on the cycle the count reaches div.
module clk_prescaler #(
    parameter int DIV_W_P = 16
) (
    input  logic               clk,
    input  logic               srst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [DIV_W_P-1:0] div,
    output logic               tick
);
    logic [DIV_W_P-1:0] cnt_r;
    assign tick = en && cnt_r == div;
    always_ff @(posedge clk) begin
        if (!srst_n || clr)
            cnt_r <= DIV_W_P'(1);
        else if (en)
            cnt_r <= tick ? DIV_W_P'(1) : cnt_r + DIV_W_P'(1);
    end
endmodule

// File: rtl/lfsr_burst_gen.sv
// lfsr_burst_gen: emits rep full LFSR periods at a prescaled chip rate, then stops.
module lfsr_burst_gen
    import lfsr_pkg::*;
#(
    parameter int WIDTH_P = 16,
    parameter int DIV_W_P = 16,
    parameter int REP_W_P = 8,
    localparam int LEN_W = $clog2(WIDTH_P + 1)
) (
    input  logic               clk,
    input  logic               srst_n,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [WIDTH_P-1:0] mask_i,
    input  logic [WIDTH_P-1:0] seed_i,
    input  logic [DIV_W_P-1:0] sel_div_i,
    input  logic [REP_W_P-1:0] rep_i,
    output logic               sig_o,
    output logic               chip_stb_o,
    output logic               busy_o,
    output logic               done_o
);
    state_t state_r, state_nx;
    logic start_last_r, armed_r, start_edge, latch, tick, run_tick, period_end, last_rep, msb;
    logic [LEN_W-1:0] n_c, n_r;
    logic [WIDTH_P-1:0] len_m, run_m, mask_c, seed_m, lfsr_r, lfsr_nx, mask_r, seed_r;
    logic [DIV_W_P-1:0] div_r;
    logic [REP_W_P-1:0] rep_r, rep_cnt_r;

    // armed_r blocks a start_i held high through reset from looking like an edge
    assign start_edge = armed_r & start_i & ~start_last_r;
    assign n_c = (len_i < LEN_W'(LEN_MIN)) ? LEN_W'(LEN_MIN) :
                 (len_i > LEN_W'(WIDTH_P)) ? LEN_W'(WIDTH_P) : len_i;
    assign len_m = WIDTH_P'(len_mask(int'(n_c)));
    assign mask_c = (mask_i | (len_m ^ (len_m >> 1))) & len_m;
    assign seed_m = seed_i & len_m;
    assign run_m = WIDTH_P'(len_mask(int'(n_r)));
    assign msb = |(lfsr_r & (run_m ^ (run_m >> 1)));
    assign lfsr_nx = WIDTH_P'(lfsr_next(word_t'(lfsr_r), word_t'(mask_r), int'(n_r)));
    assign period_end = lfsr_nx == seed_r;
    assign last_rep = rep_cnt_r == rep_r;
    assign run_tick = tick & busy_o;

    clk_prescaler #(.DIV_W_P(DIV_W_P)) u_presc (
        .clk(clk), .srst_n(srst_n), .clr(~busy_o), .en(busy_o), .div(div_r), .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (!srst_n)
            state_r <= ST_IDLE;
        else
            state_r <= state_nx;
    end

    always_comb begin
        state_nx = ST_IDLE;
        case (state_r)
            ST_IDLE: state_nx = start_edge ? ST_RUN : ST_IDLE;
            ST_RUN:  state_nx = (abort_i || (run_tick && period_end && last_rep)) ? ST_IDLE : ST_RUN;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = state_r == ST_RUN;
        latch = state_r == ST_IDLE && start_edge;
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            start_last_r <= 1'b0;
            armed_r <= 1'b0;
            lfsr_r <= WIDTH_P'(1);
            rep_cnt_r <= REP_W_P'(1);
            n_r <= LEN_W'(LEN_MIN);
            mask_r <= '0;
            seed_r <= WIDTH_P'(1);
            div_r <= DIV_W_P'(1);
            rep_r <= REP_W_P'(1);
            sig_o <= 1'b0;
            chip_stb_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            start_last_r <= start_i;
            armed_r <= 1'b1;
            chip_stb_o <= run_tick;
            done_o <= run_tick & period_end & last_rep & ~abort_i;
            if (latch) begin
                n_r <= n_c;
                mask_r <= mask_c;
                seed_r <= (seed_m == '0) ? WIDTH_P'(1) : seed_m;
                lfsr_r <= (seed_m == '0) ? WIDTH_P'(1) : seed_m;
                div_r <= (sel_div_i == '0) ? DIV_W_P'(1) : sel_div_i;
                rep_r <= (rep_i == '0) ? REP_W_P'(1) : rep_i;
                rep_cnt_r <= REP_W_P'(1);
            end else if (run_tick) begin
                sig_o <= msb;
                lfsr_r <= lfsr_nx;
                if (period_end && !last_rep)
                    rep_cnt_r <= rep_cnt_r + REP_W_P'(1);
            end
        end
    end
endmodule

// File: tb/tb_lfsr_burst_gen.sv
// tb_lfsr_burst_gen: directed bursts with hand-computed chip patterns, counts and timing.
module tb_lfsr_burst_gen;
    logic clk = 1'b0;
    logic srst_n = 1'b0;
    logic start_i = 1'b0;
    logic abort_i = 1'b0;
    logic [4:0] len_i = 5'd3;
    logic [15:0] mask_i = '0;
    logic [15:0] seed_i = '0;
    logic [15:0] sel_div_i = '0;
    logic [7:0] rep_i = '0;
    logic sig_o, chip_stb_o, busy_o, done_o;
    int n_assert = 0;
    int n_fail = 0;
    int nstb, ndone, nbusy, done_bad, gap_bad, busy_cnt;
    logic sig_a [0:63];

    lfsr_burst_gen dut (
        .clk(clk), .srst_n(srst_n), .start_i(start_i), .abort_i(abort_i),
        .len_i(len_i), .mask_i(mask_i), .seed_i(seed_i), .sel_div_i(sel_div_i),
        .rep_i(rep_i), .sig_o(sig_o), .chip_stb_o(chip_stb_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_burst(input logic [4:0] len, input logic [15:0] mask, input logic [15:0] seed,
                               input logic [15:0] div, input logic [7:0] rep);
        @(negedge clk);
        len_i = len; mask_i = mask; seed_i = seed; sel_div_i = div; rep_i = rep;
        start_i = 1'b1;
    endtask

    // watch a fixed window of cycles after the start edge; retrig/abort_at pulse inputs at that cycle
    task automatic collect(input int max_cyc, input int gap, input int retrig, input int abort_at);
        int last;
        nstb = 0; ndone = 0; nbusy = 0; done_bad = 0; gap_bad = 0; last = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (chip_stb_o) begin
                if (nstb < 64) sig_a[nstb] = sig_o;
                if (gap > 0 && nstb > 0 && c - last != gap) gap_bad++;
                last = c;
                nstb++;
            end
            if (done_o) begin
                ndone++;
                if (!chip_stb_o) done_bad++;
            end
            if (busy_o) nbusy++;
            start_i = (c == retrig);
            abort_i = (c == abort_at);
        end
        start_i = 1'b0;
        abort_i = 1'b0;
    endtask

    function automatic logic [31:0] first_bits(input int k);
        logic [31:0] r = '0;
        for (int i = 0; i < k; i++) r = {r[30:0], sig_a[i]};
        return r;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sig", 32'(sig_o), 0);
        check("rst_stb", 32'(chip_stb_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        srst_n = 1'b1;
        repeat (3) @(negedge clk);

        start_burst(5'd3, 16'h0006, 16'h0001, 16'd1, 8'd1);
        collect(20, 1, -1, -1);
        check("t1_nstb", nstb, 7);
        check("t1_bits", first_bits(7), 32'h17);
        check("t1_done", ndone, 1);
        check("t1_done_align", done_bad, 0);
        check("t1_busy", nbusy, 7);
        check("t1_gap", gap_bad, 0);
        check("t1_sig_hold", 32'(sig_o), 1);

        start_burst(5'd3, 16'h0006, 16'h0001, 16'd4, 8'd3);
        collect(100, 4, -1, -1);
        check("t2_nstb", nstb, 21);
        check("t2_bits", first_bits(21), 32'h5CB97);
        check("t2_done", ndone, 1);
        check("t2_busy", nbusy, 84);
        check("t2_gap", gap_bad, 0);

        start_burst(5'd4, 16'h0000, 16'h0005, 16'd1, 8'd2);
        collect(20, 1, -1, -1);
        check("t3_nstb", nstb, 4);
        check("t3_bits", first_bits(4), 32'h5);
        check("t3_done", ndone, 1);

        start_burst(5'd5, 16'h0014, 16'h0001, 16'd4, 8'd1);
        collect(30, 4, -1, 13);
        check("t4_abort_nstb", nstb, 3);
        check("t4_abort_bits", first_bits(3), 0);
        check("t4_abort_done", ndone, 0);
        check("t4_abort_busy", nbusy, 13);
        start_burst(5'd5, 16'h0014, 16'h0001, 16'd1, 8'd1);
        collect(50, 1, -1, -1);
        check("t4_restart_nstb", nstb, 31);
        check("t4_restart_bits", first_bits(5), 32'h1);
        check("t4_restart_done", ndone, 1);

        start_burst(5'd2, 16'hFFFE, 16'hFFF8, 16'd0, 8'd0);
        collect(20, 1, 3, -1);
        check("t5_nstb", nstb, 7);
        check("t5_bits", first_bits(7), 32'h17);
        check("t5_done", ndone, 1);
        check("t5_busy", nbusy, 7);

        start_burst(5'd3, 16'h0006, 16'h0001, 16'd1, 8'd1);
        collect(20, 1, -1, 7);
        check("t6_abort_last_nstb", nstb, 7);
        check("t6_abort_last_done", ndone, 0);
        check("t6_abort_last_busy", nbusy, 7);

        start_burst(5'd3, 16'h0006, 16'h0001, 16'd4, 8'd3);
        collect(14, 4, -1, -1);
        check("t7_pre_rst_sig", 32'(sig_o), 1);
        srst_n = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        check("t7_rst_sig", 32'(sig_o), 0);
        check("t7_rst_stb", 32'(chip_stb_o), 0);
        check("t7_rst_busy", 32'(busy_o), 0);
        check("t7_rst_done", 32'(done_o), 0);
        srst_n = 1'b1;
        busy_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
        end
        check("t7_held_start_busy", busy_cnt, 0);
        start_i = 1'b0;
        start_burst(5'd3, 16'h0006, 16'h0001, 16'd1, 8'd1);
        collect(20, 1, -1, -1);
        check("t7_after_nstb", nstb, 7);
        check("t7_after_done", ndone, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
